// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM encoding, BCD digit limits and LED bit indices for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

    localparam int LED_RUN  = 0;
    localparam int LED_WRAP = 1;
    localparam int LED_LAP  = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser plus stability counter; one-cycle pulse on accepted 0->1
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            press <= 1'b0;
            // Any cycle where the synced level matches the accepted one restarts the count.
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    level <= sync2;
                    press <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// rtl/stopwatch_bcd_ctrl.sv - MM:SS BCD stopwatch with debounced start/stop and clear buttons
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic               btn_lap,
`endif
    output logic [DIGIT_W-1:0] seg0,
    output logic [DIGIT_W-1:0] seg1,
    output logic [DIGIT_W-1:0] seg2,
    output logic [DIGIT_W-1:0] seg3,
    output logic [7:0]         led
);

    localparam int PRE_W = $clog2(TICK_DIV);

    sw_state_t          state;
    sw_state_t          state_next;
    logic               do_clear;
    logic               tick;
    logic               ss_p;
    logic               clr_p;
    logic               ss_level_unused;
    logic               clr_level_unused;
    logic [PRE_W-1:0]   presc;
    logic [DIGIT_W-1:0] d0, d1, d2, d3;
    logic               wrap;
    logic               lap_hold;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk(clk), .reset(reset), .btn_in(btn_start_stop),
        .level(ss_level_unused), .press(ss_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .reset(reset), .btn_in(btn_clear),
        .level(clr_level_unused), .press(clr_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outside RUN clear outranks start/stop; in RUN clear is ignored.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (clr_p) begin
                    do_clear = 1'b1;
                end else if (ss_p) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (ss_p) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (clr_p) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end else if (ss_p) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tick = (state == RUN) && (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (do_clear || state == IDLE) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            wrap <= 1'b0;
        end else if (do_clear) begin
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            wrap <= 1'b0;
        end else if (tick) begin
            if (d3 != UNITS_MAX) begin
                d3 <= d3 + 4'd1;
            end else begin
                d3 <= '0;
                if (d2 != TENS_MAX) begin
                    d2 <= d2 + 4'd1;
                end else begin
                    d2 <= '0;
                    if (d1 != UNITS_MAX) begin
                        d1 <= d1 + 4'd1;
                    end else begin
                        d1 <= '0;
                        if (d0 != TENS_MAX) begin
                            d0 <= d0 + 4'd1;
                        end else begin
                            d0   <= '0;
                            wrap <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic               lap_p;
    logic               lap_level_unused;
    logic [DIGIT_W-1:0] lap_d0, lap_d1, lap_d2, lap_d3;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk(clk), .reset(reset), .btn_in(btn_lap),
        .level(lap_level_unused), .press(lap_p)
    );

    // Leaving RUN always drops the hold, even if a lap press lands on the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
            lap_d0   <= '0;
            lap_d1   <= '0;
            lap_d2   <= '0;
            lap_d3   <= '0;
        end else if (state_next != RUN) begin
            lap_hold <= 1'b0;
        end else if (state == RUN && lap_p) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) begin
                lap_d0 <= d0;
                lap_d1 <= d1;
                lap_d2 <= d2;
                lap_d3 <= d3;
            end
        end
    end

    assign seg0 = lap_hold ? lap_d0 : d0;
    assign seg1 = lap_hold ? lap_d1 : d1;
    assign seg2 = lap_hold ? lap_d2 : d2;
    assign seg3 = lap_hold ? lap_d3 : d3;
`else
    assign lap_hold = 1'b0;
    assign seg0     = d0;
    assign seg1     = d1;
    assign seg2     = d2;
    assign seg3     = d3;
`endif

    always_comb begin
        led           = 8'h00;
        led[LED_RUN]  = (state == RUN);
        led[LED_WRAP] = wrap;
        led[LED_LAP]  = lap_hold;
    end

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// tb/tb_stopwatch_bcd_ctrl.sv - bench for stopwatch_bcd_ctrl with an elapsed-seconds model and directed checks
module tb_stopwatch_bcd_ctrl;

    localparam int TICK_DIV = 10;
    localparam int DEB      = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ss    = 1'b0;
    logic       clr   = 1'b0;
    logic       lap   = 1'b0;
    logic [3:0] seg0, seg1, seg2, seg3;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_entry = 0;
    int pause_entry = 0;
    logic last_run = 1'b0;

    // Model: whole elapsed seconds, prescaler count, and per-button debounce history.
    int m_state;
    int m_presc;
    int m_secs;
    int m_lap_secs;
    bit m_wrap;
    bit m_lap_hold;
    bit b_s1[3];
    bit b_s2[3];
    bit b_lvl[3];
    bit b_press[3];
    int b_run[3];

    stopwatch_bcd_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .clk(clk),
        .reset(reset),
        .btn_start_stop(ss),
        .btn_clear(clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap(lap),
`endif
        .seg0(seg0),
        .seg1(seg1),
        .seg2(seg2),
        .seg3(seg3),
        .led(led)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_secs = 0; m_lap_secs = 0;
        m_wrap = 1'b0; m_lap_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_s1[i] = 1'b0; b_s2[i] = 1'b0; b_lvl[i] = 1'b0; b_press[i] = 1'b0; b_run[i] = 0;
        end
    endtask

    task automatic model_step();
        bit p_ss, p_clr, p_lap;
        bit raw_in[3];
        int old_secs;
        int nstate;
        p_ss = b_press[0]; p_clr = b_press[1]; p_lap = b_press[2];
        old_secs = m_secs;
        if (m_state == 1) begin
            if (m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                m_secs = (m_secs + 1) % 3600;
                if (m_secs == 0) m_wrap = 1'b1;
            end else begin
                m_presc++;
            end
        end
        nstate = m_state;
        case (m_state)
            0: begin
                if (p_clr) begin m_secs = 0; m_presc = 0; m_wrap = 1'b0; end
                else if (p_ss) begin nstate = 1; m_presc = 0; end
            end
            1: begin
                if (p_ss) nstate = 2;
                if (p_lap) begin
                    if (m_lap_hold) m_lap_hold = 1'b0;
                    else begin m_lap_hold = 1'b1; m_lap_secs = old_secs; end
                end
            end
            default: begin
                if (p_clr) begin nstate = 0; m_secs = 0; m_presc = 0; m_wrap = 1'b0; end
                else if (p_ss) nstate = 1;
            end
        endcase
        if (nstate != 1) m_lap_hold = 1'b0;
        m_state = nstate;
        raw_in[0] = ss; raw_in[1] = clr; raw_in[2] = lap;
        for (int i = 0; i < 3; i++) begin
            b_press[i] = 1'b0;
            if (b_s2[i] != b_lvl[i]) begin
                b_run[i]++;
                if (b_run[i] == DEB) begin
                    b_lvl[i] = b_s2[i];
                    b_press[i] = b_s2[i];
                    b_run[i] = 0;
                end
            end else begin
                b_run[i] = 0;
            end
            b_s2[i] = b_s1[i];
            b_s1[i] = raw_in[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin
        int sh;
        logic [23:0] exp;
        forever begin
            @(negedge clk);
            sh = m_lap_hold ? m_lap_secs : m_secs;
            exp = {4'(sh / 600), 4'((sh / 60) % 10), 4'((sh % 60) / 10), 4'(sh % 10),
                   5'b0, m_lap_hold, m_wrap, (m_state == 1)};
            check("model_outputs", {8'h00, seg0, seg1, seg2, seg3, led}, {8'h00, exp});
            if (led[0] && !last_run) run_entry = cyc;
            if (!led[0] && last_run) pause_entry = cyc;
            last_run = led[0];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge: raises the chosen raw buttons for 8 cycles, then lets things settle.
    task automatic press(input bit do_ss, input bit do_clr, input bit do_lap);
        ss = do_ss; clr = do_clr; lap = do_lap;
        repeat (8) @(negedge clk);
        ss = 1'b0; clr = 1'b0; lap = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int c0, r2, r3, r4;
`ifdef STOPWATCH_LAP_EN
        int r5;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0);
        check("idle_led", {24'h0, led}, 32'h0);

        for (int g = 0; g < 3; g++) begin
            ss = 1'b1; @(negedge clk);
            ss = 1'b0; repeat (2) @(negedge clk);
        end
        ss = 1'b1; repeat (3) @(negedge clk);
        ss = 1'b0; repeat (10) @(negedge clk);
        check("glitch_no_press", {24'h0, led}, 32'h0);

        c0 = cyc;
        press(1'b1, 1'b0, 1'b0);
        check("press_latency", run_entry - c0, 7);
        wait_cyc(run_entry + 9);
        check("seg3_before_tick", {28'h0, seg3}, 1'b0);
        @(negedge clk);
        check("seg3_first_tick", {28'h0, seg3}, 32'd1);
        check("running_led", {24'h0, led}, 32'h01);
        wait_cyc(run_entry + 100);
        check("ten_ticks", {24'h0, seg2, seg3}, 32'h10);

        wait_cyc(run_entry + 109);
        press(1'b1, 1'b0, 1'b0);
        check("pause_presc_6", (pause_entry - run_entry) % 10, 6);
        repeat (50) @(negedge clk);
        check("pause_frozen", {16'h0, seg0, seg1, seg2, seg3}, 32'h0011);
        check("pause_led", {24'h0, led}, 32'h0);

        c0 = cyc;
        ss = 1'b1;
        wait_cyc(c0 + 7);
        check("resume_run", {24'h0, led}, 32'h01);
        wait_cyc(c0 + 8);
        ss = 1'b0;
        r2 = c0 + 7;
        wait_cyc(r2 + 3);
        check("resume_no_tick_yet", {16'h0, seg0, seg1, seg2, seg3}, 32'h0011);
        wait_cyc(r2 + 4);
        check("resume_tick_4", {16'h0, seg0, seg1, seg2, seg3}, 32'h0012);

        wait_cyc(r2 + 35864);
        check("at_5958", {16'h0, seg0, seg1, seg2, seg3}, 32'h5958);
        wait_cyc(r2 + 35874);
        check("at_5959", {16'h0, seg0, seg1, seg2, seg3}, 32'h5959);
        check("no_wrap_yet", {24'h0, led}, 32'h01);
        wait_cyc(r2 + 35884);
        check("wrapped_0000", {16'h0, seg0, seg1, seg2, seg3}, 32'h0000);
        check("wrap_led", {24'h0, led}, 32'h03);
        wait_cyc(r2 + 35909);
        check("wrap_sticky", {24'h0, led}, 32'h03);

        press(1'b0, 1'b1, 1'b0);
        check("clear_in_run_ignored", {24'h0, led}, 32'h03);
        press(1'b1, 1'b0, 1'b0);
        check("paused_wrap_led", {24'h0, led}, 32'h02);
        press(1'b0, 1'b1, 1'b0);
        check("clear_pause_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0);
        check("clear_pause_led", {24'h0, led}, 32'h0);

        press(1'b1, 1'b0, 1'b0);
        r3 = run_entry;
        wait_cyc(r3 + 40);
        press(1'b1, 1'b1, 1'b0);
        check("both_in_run_led", {24'h0, led}, 32'h0);
        check("both_in_run_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0004);
        press(1'b1, 1'b1, 1'b0);
        check("both_in_pause_led", {24'h0, led}, 32'h0);
        check("both_in_pause_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0);

        press(1'b1, 1'b0, 1'b0);
        r4 = run_entry;
        wait_cyc(r4 + 7545);
        check("at_1234", {16'h0, seg0, seg1, seg2, seg3}, 32'h1234);
        #2 reset = 1'b1;
        #1;
        check("async_reset_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0);
        check("async_reset_led", {24'h0, led}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {8'h0, seg0, seg1, seg2, seg3, led}, 32'h0);

`ifdef STOPWATCH_LAP_EN
        press(1'b1, 1'b0, 1'b0);
        r5 = run_entry;
        wait_cyc(r5 + 30);
        press(1'b0, 1'b0, 1'b1);
        wait_cyc(r5 + 80);
        check("lap_hold_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0003);
        check("lap_hold_led", {24'h0, led}, 32'h05);
        lap = 1'b1;
        wait_cyc(r5 + 88);
        check("lap_release_segs", {16'h0, seg0, seg1, seg2, seg3}, 32'h0008);
        check("lap_release_led", {24'h0, led}, 32'h01);
        lap = 1'b0;
        repeat (10) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_ctrl.md
Name: stopwatch_bcd_ctrl

Overview:
- Upstream digit source for the TM1638 display driver: an MM:SS stopwatch, 00:00 to 59:59, in BCD.
- Debounces two push-buttons (start/stop, clear) and runs a 3-state control FSM.
- Divides the system clock to a seconds tick and presents four BCD digits plus status LEDs, ready to wire to the driver's seg/led inputs.
- Runs on the 50 MHz system clock; the driver keeps its own divided clock.

Parameters:
- TICK_DIV, 50000000: system-clock cycles per counted second; must be >= 2.
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn_start_stop  input  1  raw button, active-high, asynchronous to clk.
- btn_clear  input  1  raw button, active-high, asynchronous to clk.
- seg0  output  4  minutes tens, BCD 0-5 (leftmost digit).
- seg1  output  4  minutes units, BCD 0-9.
- seg2  output  4  seconds tens, BCD 0-5.
- seg3  output  4  seconds units, BCD 0-9.
- led  output  8  led[0] = running; led[1] = sticky wrap flag; led[7:2] = 0.

Behaviour:
- Reset (async assert, synchronous release): FSM = IDLE; all digits 0; prescaler 0; wrap flag 0; debouncers hold accepted level 0 with synchronisers cleared; led = 8'h00. Reset mid-run discards all state.
- Debounce, per button:
  - 2-FF synchroniser, then a stability counter.
  - When the synced level differs from the accepted level for DEB_CYCLES consecutive cycles, the accepted level updates; any bounce restarts the count.
  - A 0->1 change of the accepted level emits a 1-cycle press pulse. Release produces no pulse.
- FSM states: IDLE, RUN, PAUSE. A press pulse at edge N updates the state at edge N+1.
  - IDLE + start_stop -> RUN; prescaler starts from 0.
  - RUN + start_stop -> PAUSE; prescaler value is held, so the partial second is kept.
  - PAUSE + start_stop -> RUN; prescaler resumes from the held value.
  - PAUSE or IDLE + clear -> IDLE; digits, prescaler and wrap flag cleared.
  - RUN + clear: ignored.
  - Both pulses in the same cycle: in RUN, start_stop acts and clear is dropped; in PAUSE or IDLE, clear wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - The cycle it equals TICK_DIV-1 produces the tick and reloads 0.
  - The digits increment on that same edge, so the displayed value changes one cycle after the tick cycle.
- BCD cascade, per tick:
  - seg3 increments; 9 -> 0 carries into seg2.
  - seg2 5 -> 0 carries into seg1.
  - seg1 9 -> 0 carries into seg0.
  - seg0 5 -> 0 means 59:59 -> 00:00; this sets the wrap flag, counting continues, and the flag stays set until clear.
  - Digits never hold non-BCD values.
- Outputs are registered. led[0] = 1 exactly while in RUN.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input btn_lap (1 bit, active-high, debounced like the other buttons).
  - In RUN, a lap press copies the live digits into a lap register and sets lap_hold; seg0..seg3 then show the lap register while counting continues internally.
  - A second lap press clears lap_hold and the live digits are shown again.
  - led[2] = lap_hold.
  - Entering PAUSE or IDLE clears lap_hold.
  - Lap presses in PAUSE or IDLE are ignored.
- Undefined: port btn_lap is absent; seg0..seg3 always show the live digits; led[2] = 0.

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2.
  - BCD digit width (4) and digit limits (9 for units, 5 for tens).
  - LED bit indices (running, wrap, lap).
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, reset, btn_in, level, press): instantiated once per button.

Test Plan (TICK_DIV=10, DEB_CYCLES=4):
- Reset then idle 100 cycles -> seg0..seg3 = 0,0,0,0; led = 8'h00.
- start_stop high for 8 cycles, with 1-cycle glitches beforehand -> exactly one press; glitches shorter than 4 cycles produce no press; led[0]=1; seg3 = 1 exactly 10 cycles after RUN entry; after 10 ticks seg2:seg3 = 1:0.
- Stop at prescaler = 6, wait 50 cycles, restart -> digits frozen during PAUSE; next tick arrives 4 cycles after RUN resumes (prescaler values 6..9).
- Force 59:58 then run 2 ticks -> 59:59, then 00:00; led[1]=1 and stays set; clear in RUN is ignored; clear in PAUSE -> 00:00 and led[1]=0.
- start_stop and clear pulses in the same cycle in PAUSE -> IDLE with digits cleared; same pulses in RUN -> PAUSE with digits kept.
- Assert reset mid-count at 12:34 -> all outputs 0 immediately (asynchronously), FSM in IDLE after release. Under STOPWATCH_LAP_EN: lap at 00:03 -> display holds 00:03 while counting; second lap after 5 ticks -> display shows 00:08.
